reg_alu_core: RTL



---
 rtl/reg_alu_core.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/reg_alu_core.sv
// reg_alu_core - multi-cycle, single-issue execute unit with an internal
// register file and a registered flag set.
//
// One instruction is accepted per valid/ready handshake. It then walks
// IDLE -> READ -> EXEC -> RESP. Illegal opcodes go straight from IDLE to RESP.
//
// Ports
//   clk, rst_n       : clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready: instruction handshake; accepted when both are high
//   opcode,rd,rs1,rs2: operation, destination index and source indices
//   imm              : immediate operand for LDI
//   out_valid        : one-cycle completion pulse, high during RESP
//   res,cf,zf,sf,vf  : result and flags of the last legal completion
//   invalid          : the last completed opcode was illegal
module reg_alu_core #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [AW-1:0]    rd,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             vf,
    output logic             invalid
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [AW-1:0]    rd;
        logic [AW-1:0]    rs1;
        logic [AW-1:0]    rs2;
        logic [WIDTH-1:0] imm;
    } instr_t;

    state_t                       state, state_n;
    instr_t                       ins;
    logic [NREGS-1:0][WIDTH-1:0]  regs;
    logic [WIDTH-1:0]             a, b;
    logic [WIDTH-1:0]             alu_res;
    logic                         alu_cf, alu_vf;
    logic [WIDTH:0]               sum, diff;
    logic                         accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);
    assign accept    = in_valid && in_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = (opcode == OP_ILL) ? RESP : READ;
            READ: state_n = EXEC;
            EXEC: state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------- instruction and operand latches ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins <= '0;
            a   <= '0;
            b   <= '0;
        end else begin
            if (accept) ins <= '{op: opcode, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
            // Operands are captured before the EXEC write, so rs==rd sees
            // the old value.
            if (state == READ) begin
                a <= regs[ins.rs1];
                b <= regs[ins.rs2];
            end
        end
    end

    // ---------------- ALU ----------------
    // One extra bit holds the carry out of ADD and the borrow of SUB/CMP.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_vf  = 1'b0;
        case (ins.op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_LDI: alu_res = ins.imm;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_vf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[WIDTH-1:0];
                alu_cf  = diff[WIDTH];
                alu_vf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: ;
        endcase
    end

    // ---------------- result, flags, invalid ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res     <= '0;
            cf      <= 1'b0;
            zf      <= 1'b0;
            sf      <= 1'b0;
            vf      <= 1'b0;
            invalid <= 1'b0;
        end else if (state == EXEC) begin
            res     <= alu_res;
            cf      <= alu_cf;
            zf      <= (alu_res == '0);
            sf      <= alu_res[WIDTH-1];
            vf      <= alu_vf;
            invalid <= 1'b0;
        end else if (accept && opcode == OP_ILL) begin
            // Illegal op leaves result and flags untouched.
            invalid <= 1'b1;
        end
    end

    // ---------------- register file (single write port) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (state == EXEC && ins.op != OP_CMP)
            regs[ins.rd] <= alu_res;
    end

endmodule
